alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single 64-bit ALU between two requesters: port 0 is the pipeline EX stage and port 1 is the branch/address helper unit.
- Round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Drives the ALU's 3-bit `cntrl` encoding and operands, holds them for a configurable number of cycles, then returns the result to the granted requester.
- Owns the architectural NZVC flag register, updated only by flag-setting ops (ADDS/SUBS/ADDIS/SUBIS).

Parameters:
- WIDTH, 64, operand/result width.
- ALU_LAT, 1, cycles operands are held stable on the ALU before the result is sampled; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  request valid; bit i belongs to requester i.
- req_ready  out  2  request accepted this cycle (one-hot or zero).
- req_op0, req_op1  in  3 each  ALU cntrl code (000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor).
- req_a0, req_a1, req_b0, req_b1  in  WIDTH each  operands.
- req_setf  in  2  request updates NZVC.
- resp_valid  out  2  response valid, one-hot or zero.
- resp_ready  in  2  requester consumes the response.
- resp_result  out  WIDTH  result for the requester with resp_valid set.
- resp_err  out  1  illegal op (001 or 111); qualified by resp_valid.
- alu_cntrl  out  3  to ALU.
- alu_a, alu_b  out  WIDTH each  to ALU.
- alu_result  in  WIDTH  from ALU.
- alu_negative, alu_zero, alu_overflow, alu_carry_out  in  1 each  from ALU.
- flags  out  4  NZVC register, {N,Z,V,C}.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: req_ready=0, resp_valid=0, resp_result=0, resp_err=0, alu_cntrl=000, alu_a=0, alu_b=0, flags=0000, busy=0, rr_ptr=0.
- IDLE, arbitration:
  - If only one req_valid bit is set, that requester is granted.
  - If both are set, the requester selected by rr_ptr is granted.
  - req_ready[g] is asserted combinationally in the same cycle, so acceptance is the same cycle.
  - On acceptance: register op, a, b and setf; store grant index g; set rr_ptr = ~g; load the counter with ALU_LAT-1; go to EXEC.
- IDLE, illegal op:
  - A granted op of 001 or 111 is still accepted.
  - The FSM skips EXEC and goes to RESP with resp_result=0 and resp_err=1.
  - Flags are never updated for an illegal op.
- EXEC:
  - alu_cntrl/alu_a/alu_b are driven from registers and held stable for the whole state.
  - The counter decrements each cycle.
  - When the counter reaches 0: capture alu_result into resp_result and set resp_err=0.
  - If the stored setf=1, also load flags <= {alu_negative, alu_zero, alu_overflow, alu_carry_out}.
  - Then go to RESP.
- ALU outputs outside EXEC: held at their last values, not forced to zero.
- RESP:
  - resp_valid[g]=1; resp_result is held stable.
  - On resp_ready[g], go to IDLE; resp_valid drops in the next cycle.
  - resp_ready on the non-granted bit is ignored.
- Pipelining: no overlap between operations; req_ready=0 in EXEC and RESP.
- Latency: accept to resp_valid is ALU_LAT+1 cycles (1 cycle for an illegal op).
- Throughput: at best one op per ALU_LAT+2 cycles.
- Flags timing: flags change exactly on the EXEC→RESP edge, are visible from the RESP cycle onward, and are held otherwise.
- Pass-B (000) with setf=1: flags are still loaded from the ALU flag outputs.
- Reset mid-operation: async reset_n low returns to IDLE immediately. Any in-flight request is dropped with no response, and flags clear to 0000.
- Requester rule: a requester must hold its req_* inputs stable while req_valid is high and not yet accepted. The arbiter does not check this.

Optional Feature:
- Macro: ALU_SHARE_ARBITER_STATS_EN.
- When defined:
  - Adds output ports grant_cnt0 and grant_cnt1 (16 bits each).
  - Each counter increments on every acceptance for its requester and saturates at 16'hFFFF.
  - Both clear on reset.
  - Adds output illegal_cnt (8 bits, saturating) that counts resp_err responses.
- When undefined: these ports and registers do not exist, and all other behaviour is identical.

Test Plan:
1. Reset, then single request: req_valid=01, op=010, a=5, b=7, setf=1, ALU_LAT=1, ALU model combinational.
   - Accepted in cycle 0; resp_valid=01 in cycle 2 with result=12.
   - flags=0000 (N=0, Z=0, no V, no C).
2. SUBS to zero on port 1: op=011, a=b=64'h10, setf=1.
   - resp_result=0, flags Z=1.
   - A following port-0 AND with setf=0 leaves flags unchanged.
3. Contention: both req_valid high every cycle with resp_ready always high.
   - Grants alternate 0,1,0,1 over 4 ops.
   - Consecutive acceptances are ALU_LAT+2 cycles apart.
4. Backpressure: resp_ready held low for 5 cycles in RESP.
   - resp_valid and resp_result stay stable; req_ready stays 0 throughout.
   - The next grant comes the cycle after resp_ready rises.
5. Illegal op 111 on port 0 with setf=1.
   - resp_valid 1 cycle after accept, resp_err=1, resp_result=0.
   - flags unchanged; no ALU operand update.
6. Reset mid-EXEC: drop reset_n during EXEC with ALU_LAT=4.
   - Outputs go to reset values asynchronously; no resp_valid for the dropped op.
   - A new request after reset is served normally.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Requester-side request/response bundle for the shared-ALU arbiter (two requesters, bit i = requester i).
// The master drives requests and consumes responses; the slave arbitrates and answers.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 64
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2:0]       req_op0;
  logic [2:0]       req_op1;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_b1;
  logic [1:0]       req_setf;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_err;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, req_setf, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_err
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, req_setf, resp_ready,
    output req_ready, resp_valid, resp_result, resp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between EX stage (0) and branch helper (1); owns NZVC. Stats: ALU_SHARE_ARBITER_STATS_EN.
// Accept->resp_valid is ALU_LAT+1 cycles (1 for illegal ops); one op in flight, response held until resp_ready.
module alu_share_arbiter #(
  parameter int WIDTH   = 64,
  parameter int ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_share_arbiter_if.slave  rq,
  output logic [2:0]          alu_cntrl,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_negative,
  input  logic                alu_zero,
  input  logic                alu_overflow,
  input  logic                alu_carry_out,
  output logic [3:0]          flags,
  output logic                busy
`ifdef ALU_SHARE_ARBITER_STATS_EN
  ,
  output logic [15:0]         grant_cnt0,
  output logic [15:0]         grant_cnt1,
  output logic [7:0]          illegal_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             setf;
  } req_t;

  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  req_t       sel;
  logic       grant;
  logic       accept;
  logic       illegal;
  logic       gnt_q;
  logic       rr_ptr;
  logic       setf_q;
  logic [3:0] cnt;
  logic [1:0] req_ready_c;

  // Arbitration and next state; req_ready is combinational so acceptance is same-cycle.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    req_ready_c = 2'b00;
    grant       = rr_ptr;
    if (rq.req_valid != 2'b11) begin
      grant = rq.req_valid[1];
    end
    sel.op   = grant ? rq.req_op1     : rq.req_op0;
    sel.a    = grant ? rq.req_a1      : rq.req_a0;
    sel.b    = grant ? rq.req_b1      : rq.req_b0;
    sel.setf = grant ? rq.req_setf[1] : rq.req_setf[0];
    illegal  = (sel.op == 3'b001) || (sel.op == 3'b111);
    case (state)
      IDLE: begin
        if (reset_n && (rq.req_valid != 2'b00)) begin
          accept      = 1'b1;
          req_ready_c = grant ? 2'b10 : 2'b01;
          state_nxt   = illegal ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rq.resp_ready[gnt_q]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ALU operands are only loaded for legal ops, so an illegal op leaves the ALU inputs untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q          <= 1'b0;
      rr_ptr         <= 1'b0;
      setf_q         <= 1'b0;
      cnt            <= 4'd0;
      alu_cntrl      <= 3'b000;
      alu_a          <= '0;
      alu_b          <= '0;
      rq.resp_result <= '0;
      rq.resp_err    <= 1'b0;
      flags          <= 4'b0000;
    end else begin
      if (accept) begin
        gnt_q  <= grant;
        rr_ptr <= ~grant;
        setf_q <= sel.setf;
        cnt    <= CNT_LOAD;
        if (illegal) begin
          rq.resp_result <= '0;
          rq.resp_err    <= 1'b1;
        end else begin
          alu_cntrl <= sel.op;
          alu_a     <= sel.a;
          alu_b     <= sel.b;
        end
      end
      if (state == EXEC) begin
        if (cnt == 4'd0) begin
          rq.resp_result <= alu_result;
          rq.resp_err    <= 1'b0;
          if (setf_q) begin
            flags <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
          end
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  assign rq.req_ready  = req_ready_c;
  assign rq.resp_valid = (state == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy          = (state != IDLE);

`ifdef ALU_SHARE_ARBITER_STATS_EN
  // Illegal ops always produce an error response, so they are counted at acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt0  <= 16'd0;
      grant_cnt1  <= 16'd0;
      illegal_cnt <= 8'd0;
    end else if (accept) begin
      if (!grant && (grant_cnt0 != 16'hFFFF)) begin
        grant_cnt0 <= grant_cnt0 + 16'd1;
      end
      if (grant && (grant_cnt1 != 16'hFFFF)) begin
        grant_cnt1 <= grant_cnt1 + 16'd1;
      end
      if (illegal && (illegal_cnt != 8'hFF)) begin
        illegal_cnt <= illegal_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance with ALU_LAT=1, one with ALU_LAT=4.
// Checks accept->resp_valid latency of ALU_LAT+1 cycles (1 for illegal ops).
// Exercises response backpressure, contention and reset mid-operation.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU: returns {N, Z, V, C, result}; C on subtract is "no borrow".
    function automatic logic [67:0] alu_f(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        logic [63:0] r;
        logic        v;
        logic        c;
        s = '0;
        r = '0;
        v = 1'b0;
        c = 1'b0;
        case (op)
            3'b000: r = b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[63:0];
                c = s[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'b011: begin
                s = {1'b0, a} + {1'b0, ~b} + 65'd1;
                r = s[63:0];
                c = s[64];
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = '0;
        endcase
        return {r[63], (r == 64'd0), v, c, r};
    endfunction

    alu_share_arbiter_if #(.WIDTH(64)) bus ();
    alu_share_arbiter_if #(.WIDTH(64)) bus4 ();

    logic [2:0]  alu_cntrl, alu_cntrl4;
    logic [63:0] alu_a, alu_b, alu_result, alu_a4, alu_b4, alu_result4;
    logic        alu_n, alu_z, alu_v, alu_c, alu_n4, alu_z4, alu_v4, alu_c4;
    logic [3:0]  flags, flags4;
    logic        busy, busy4;
`ifdef ALU_SHARE_ARBITER_STATS_EN
    logic [15:0] gc0, gc1, gc0_4, gc1_4;
    logic [7:0]  ic, ic_4;
`endif

    assign {alu_n, alu_z, alu_v, alu_c, alu_result}       = alu_f(alu_cntrl, alu_a, alu_b);
    assign {alu_n4, alu_z4, alu_v4, alu_c4, alu_result4} = alu_f(alu_cntrl4, alu_a4, alu_b4);

    alu_share_arbiter #(.WIDTH(64), .ALU_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n), .rq(bus),
        .alu_cntrl(alu_cntrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .alu_negative(alu_n), .alu_zero(alu_z), .alu_overflow(alu_v), .alu_carry_out(alu_c),
        .flags(flags), .busy(busy)
`ifdef ALU_SHARE_ARBITER_STATS_EN
        , .grant_cnt0(gc0), .grant_cnt1(gc1), .illegal_cnt(ic)
`endif
    );

    alu_share_arbiter #(.WIDTH(64), .ALU_LAT(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .rq(bus4),
        .alu_cntrl(alu_cntrl4), .alu_a(alu_a4), .alu_b(alu_b4), .alu_result(alu_result4),
        .alu_negative(alu_n4), .alu_zero(alu_z4), .alu_overflow(alu_v4), .alu_carry_out(alu_c4),
        .flags(flags4), .busy(busy4)
`ifdef ALU_SHARE_ARBITER_STATS_EN
        , .grant_cnt0(gc0_4), .grant_cnt1(gc1_4), .illegal_cnt(ic_4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set0(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic setf);
        bus.req_op0     = op;
        bus.req_a0      = a;
        bus.req_b0      = b;
        bus.req_setf[0] = setf;
    endtask

    task automatic set1(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic setf);
        bus.req_op1     = op;
        bus.req_a1      = a;
        bus.req_b1      = b;
        bus.req_setf[1] = setf;
    endtask

    initial begin
        int cyc;
        int last;
        int w;

        // Reset with a request already pending: nothing may be accepted while reset is held.
        reset_n         = 1'b0;
        bus.req_valid   = 2'b01;
        bus.resp_ready  = 2'b00;
        bus.req_setf    = 2'b00;
        set0(3'b010, 64'd5, 64'd7, 1'b1);
        set1(3'b000, 64'd0, 64'd0, 1'b0);
        bus4.req_valid  = 2'b00;
        bus4.resp_ready = 2'b00;
        bus4.req_setf   = 2'b00;
        bus4.req_op0    = 3'b000;
        bus4.req_op1    = 3'b000;
        bus4.req_a0     = '0;
        bus4.req_a1     = '0;
        bus4.req_b0     = '0;
        bus4.req_b1     = '0;
        #12;
        chk("rst_req_ready", bus.req_ready, 2'b00);
        chk("rst_resp_valid", bus.resp_valid, 2'b00);
        chk("rst_resp_result", bus.resp_result, 64'd0);
        chk("rst_resp_err", bus.resp_err, 1'b0);
        chk("rst_alu_cntrl", alu_cntrl, 3'b000);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_flags", flags, 4'b0000);
        chk("rst_busy", busy, 1'b0);

        // Step 1: ADDS 5+7 on port 0.
        tick();
        reset_n = 1'b1;
        settle();
        chk("t1_req_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        settle();
        chk("t1_busy_exec", busy, 1'b1);
        chk("t1_no_resp_yet", bus.resp_valid, 2'b00);
        chk("t1_alu_a", alu_a, 64'd5);
        tick();
        settle();
        chk("t1_resp_valid", bus.resp_valid, 2'b01);
        chk("t1_result", bus.resp_result, 64'd12);
        chk("t1_err", bus.resp_err, 1'b0);
        chk("t1_flags", flags, 4'b0000);
        bus.resp_ready = 2'b01;
        tick();
        bus.resp_ready = 2'b00;
        settle();
        chk("t1_resp_drop", bus.resp_valid, 2'b00);
        chk("t1_idle", busy, 1'b0);

        // Step 2: SUBS 0x10-0x10 on port 1 sets Z (and C = no borrow).
        set1(3'b011, 64'h10, 64'h10, 1'b1);
        bus.req_valid = 2'b10;
        settle();
        chk("t2_req_ready", bus.req_ready, 2'b10);
        tick();
        bus.req_valid = 2'b00;
        tick();
        settle();
        chk("t2_resp_valid", bus.resp_valid, 2'b10);
        chk("t2_result", bus.resp_result, 64'd0);
        chk("t2_flags", flags, 4'b0101);
        bus.resp_ready = 2'b10;
        tick();
        bus.resp_ready = 2'b00;

        // Step 3: both ports requesting continuously; pointer now favours port 0.
        set0(3'b010, 64'd1, 64'd1, 1'b0);
        set1(3'b110, 64'hFF, 64'h0F, 1'b0);
        bus.req_valid  = 2'b11;
        bus.resp_ready = 2'b11;
        cyc  = 0;
        last = 0;
        settle();
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while ((bus.req_ready == 2'b00) && (w < 10)) begin
                tick();
                settle();
                w++;
                cyc++;
            end
            chk("t3_wait_expired", (w < 10), 1'b1);
            chk("t3_grant", bus.req_ready, ((k % 2) == 0) ? 2'b01 : 2'b10);
            if (k > 0) begin
                chk("t3_gap", cyc - last, 3);
            end
            last = cyc;
            tick();
            settle();
            tick();
            settle();
            cyc += 2;
            chk("t3_resp_valid", bus.resp_valid, ((k % 2) == 0) ? 2'b01 : 2'b10);
            chk("t3_result", bus.resp_result, ((k % 2) == 0) ? 64'd2 : 64'hF0);
        end
        bus.req_valid = 2'b00;
        tick();
        bus.resp_ready = 2'b00;
        settle();
        chk("t3_flags_kept", flags, 4'b0101);

        // Step 2b: AND with setf=0 leaves flags alone; resp_ready on the other bit is ignored.
        set0(3'b100, 64'hF0, 64'h3C, 1'b0);
        bus.req_valid = 2'b01;
        settle();
        chk("t2b_req_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        tick();
        settle();
        chk("t2b_result", bus.resp_result, 64'h30);
        chk("t2b_flags", flags, 4'b0101);
        bus.resp_ready = 2'b10;
        tick();
        settle();
        chk("t2b_wrong_ready", bus.resp_valid, 2'b01);
        bus.resp_ready = 2'b01;
        tick();
        bus.resp_ready = 2'b00;

        // Step 4: response backpressure with port 0 waiting behind it.
        set1(3'b101, 64'hA0, 64'h05, 1'b0);
        bus.req_valid = 2'b10;
        settle();
        chk("t4_req_ready", bus.req_ready, 2'b10);
        tick();
        set0(3'b010, 64'd3, 64'd4, 1'b0);
        bus.req_valid = 2'b01;
        tick();
        settle();
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", bus.resp_valid, 2'b10);
            chk("t4_hold_result", bus.resp_result, 64'hA5);
            chk("t4_hold_ready", bus.req_ready, 2'b00);
            tick();
            settle();
        end
        bus.resp_ready = 2'b10;
        settle();
        chk("t4_ready_in_resp", bus.req_ready, 2'b00);
        tick();
        bus.resp_ready = 2'b00;
        settle();
        chk("t4_next_grant", bus.req_ready, 2'b01);
        chk("t4_valid_dropped", bus.resp_valid, 2'b00);
        tick();
        bus.req_valid = 2'b00;
        tick();
        settle();
        chk("t4_second_valid", bus.resp_valid, 2'b01);
        chk("t4_second_result", bus.resp_result, 64'd7);
        bus.resp_ready = 2'b01;
        tick();
        bus.resp_ready = 2'b00;

        // Step 5: illegal op 111 with setf: error response next cycle, ALU inputs and flags untouched.
        set0(3'b111, 64'h55, 64'h66, 1'b1);
        bus.req_valid = 2'b01;
        settle();
        chk("t5_req_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        settle();
        chk("t5_resp_valid", bus.resp_valid, 2'b01);
        chk("t5_err", bus.resp_err, 1'b1);
        chk("t5_result", bus.resp_result, 64'd0);
        chk("t5_flags", flags, 4'b0101);
        chk("t5_alu_a", alu_a, 64'd3);
        chk("t5_alu_cntrl", alu_cntrl, 3'b010);
        bus.resp_ready = 2'b01;
        tick();
        bus.resp_ready = 2'b00;
        settle();
        chk("t5_idle", busy, 1'b0);
`ifdef ALU_SHARE_ARBITER_STATS_EN
        chk("stats_grant0", gc0, 16'd6);
        chk("stats_grant1", gc1, 16'd4);
        chk("stats_illegal", ic, 8'd1);
`endif

        // Step 6: ALU_LAT=4 instance: latency 5, then reset in the middle of EXEC.
        bus4.req_op0     = 3'b010;
        bus4.req_a0      = 64'h7FFF_FFFF_FFFF_FFFF;
        bus4.req_b0      = 64'd1;
        bus4.req_setf[0] = 1'b1;
        bus4.req_valid   = 2'b01;
        settle();
        chk("t6_req_ready", bus4.req_ready, 2'b01);
        tick();
        bus4.req_valid = 2'b00;
        tick();
        tick();
        tick();
        settle();
        chk("t6_not_yet", bus4.resp_valid, 2'b00);
        tick();
        settle();
        chk("t6_resp_valid", bus4.resp_valid, 2'b01);
        chk("t6_result", bus4.resp_result, 64'h8000_0000_0000_0000);
        chk("t6_flags", flags4, 4'b1010);
        bus4.resp_ready = 2'b01;
        tick();
        bus4.resp_ready = 2'b00;

        bus4.req_op1     = 3'b011;
        bus4.req_a1      = 64'd9;
        bus4.req_b1      = 64'd2;
        bus4.req_setf[1] = 1'b1;
        bus4.req_valid   = 2'b10;
        settle();
        chk("t6_req_ready2", bus4.req_ready, 2'b10);
        tick();
        bus4.req_valid = 2'b00;
        tick();
        settle();
        chk("t6_busy_exec", busy4, 1'b1);
        reset_n = 1'b0;
        settle();
        chk("t6_rst_busy", busy4, 1'b0);
        chk("t6_rst_valid", bus4.resp_valid, 2'b00);
        chk("t6_rst_flags", flags4, 4'b0000);
        chk("t6_rst_alu_a", alu_a4, 64'd0);
        chk("t6_rst_alu_cntrl", alu_cntrl4, 3'b000);
        chk("t6_rst_result", bus4.resp_result, 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        settle();
        chk("t6_dropped", bus4.resp_valid, 2'b00);
        chk("t6_idle_after", busy4, 1'b0);

        // Pointer cleared by reset, so port 0 wins the tie.
        bus4.req_op0     = 3'b100;
        bus4.req_a0      = 64'hFF;
        bus4.req_b0      = 64'h0F;
        bus4.req_setf[0] = 1'b0;
        bus4.req_op1     = 3'b010;
        bus4.req_a1      = 64'd1;
        bus4.req_b1      = 64'd1;
        bus4.req_valid   = 2'b11;
        settle();
        chk("t6_rr_reset", bus4.req_ready, 2'b01);
        tick();
        bus4.req_valid = 2'b00;
        tick();
        tick();
        tick();
        tick();
        settle();
        chk("t6_new_valid", bus4.resp_valid, 2'b01);
        chk("t6_new_result", bus4.resp_result, 64'h0F);
        bus4.resp_ready = 2'b01;
        tick();
        bus4.resp_ready = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
